// File: rtl/lcd_ctrl_param_pkg.sv
// Shared types and opcodes for the parametrised LCD image controller.
package lcd_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_CMD   = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [3:0] CMD_WRITE  = 4'd0;
  localparam logic [3:0] CMD_UP     = 4'd1;
  localparam logic [3:0] CMD_DOWN   = 4'd2;
  localparam logic [3:0] CMD_LEFT   = 4'd3;
  localparam logic [3:0] CMD_RIGHT  = 4'd4;
  localparam logic [3:0] CMD_MAX    = 4'd5;
  localparam logic [3:0] CMD_MIN    = 4'd6;
  localparam logic [3:0] CMD_AVG    = 4'd7;
  localparam logic [3:0] CMD_CCW    = 4'd8;
  localparam logic [3:0] CMD_CW     = 4'd9;
  localparam logic [3:0] CMD_MIRX   = 4'd10;
  localparam logic [3:0] CMD_MIRY   = 4'd11;
  localparam logic [3:0] CMD_CENTER = 4'd12;
  localparam logic [3:0] CMD_RELOAD = 4'd13;

endpackage

// File: rtl/lcd_ctrl_param_if.sv
// Host command, IROM read and IRAM write signals of the LCD controller.
interface lcd_ctrl_param_if #(
  parameter int DATA_W = 8,
  parameter int AW     = 6
);
  logic [3:0]        cmd;
  logic              cmd_valid;
  logic [DATA_W-1:0] IROM_Q;
  logic              IROM_rd;
  logic [AW-1:0]     IROM_A;
  logic              IRAM_valid;
  logic [DATA_W-1:0] IRAM_D;
  logic [AW-1:0]     IRAM_A;
  logic              busy;
  logic              done;

  modport master (
    output cmd, cmd_valid, IROM_Q,
    input  IROM_rd, IROM_A, IRAM_valid, IRAM_D, IRAM_A, busy, done
  );

  modport slave (
    input  cmd, cmd_valid, IROM_Q,
    output IROM_rd, IROM_A, IRAM_valid, IRAM_D, IRAM_A, busy, done
  );
endinterface

// File: rtl/lcd_ctrl_param_win_alu.sv
// Combinational max/min/average of the four 2x2 window pixels.
module lcd_win_alu
  import lcd_ctrl_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int AVG_ROUND = 0
) (
  input  logic [DATA_W-1:0] p0,
  input  logic [DATA_W-1:0] p1,
  input  logic [DATA_W-1:0] p2,
  input  logic [DATA_W-1:0] p3,
  output logic [DATA_W-1:0] max_v,
  output logic [DATA_W-1:0] min_v,
  output logic [DATA_W-1:0] avg_v
);
  logic [DATA_W-1:0] hi01, hi23, lo01, lo23;
  logic [DATA_W+1:0] sum, sum_r;

  assign hi01  = (p0 > p1) ? p0 : p1;
  assign hi23  = (p2 > p3) ? p2 : p3;
  assign lo01  = (p0 < p1) ? p0 : p1;
  assign lo23  = (p2 < p3) ? p2 : p3;
  assign max_v = (hi01 > hi23) ? hi01 : hi23;
  assign min_v = (lo01 < lo23) ? lo01 : lo23;

  // two guard bits: neither the sum nor sum+2 can overflow
  assign sum   = {2'b00, p0} + {2'b00, p1} + {2'b00, p2} + {2'b00, p3};
  assign sum_r = (AVG_ROUND != 0) ? sum + (DATA_W+2)'(2) : sum;
  assign avg_v = DATA_W'(sum_r >> 2);
endmodule

// File: rtl/lcd_ctrl_param.sv
// LCD image controller: loads W x H image from IROM, edits a 2x2 window, streams to IRAM.
// state | meaning
// IDLE  | one-cycle restart point, busy
// READ  | N cycles copying IROM into the buffer
// CMD   | waiting for a host command, not busy
// WRITE | N cycles streaming the buffer to IRAM
// DONE  | one-cycle done pulse, then back to CMD
module lcd_ctrl_param
  import lcd_ctrl_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int COL_BITS  = 3,
  parameter int ROW_BITS  = 3,
  parameter int AVG_ROUND = 0
) (
  input logic             clk,
  input logic             reset,
  lcd_ctrl_param_if.slave bus
);
  localparam int AW = COL_BITS + ROW_BITS;
  localparam int N  = 1 << AW;
  localparam logic [COL_BITS-1:0] X_MID = COL_BITS'(1 << (COL_BITS - 1));
  localparam logic [ROW_BITS-1:0] Y_MID = ROW_BITS'(1 << (ROW_BITS - 1));
  localparam logic [COL_BITS-1:0] X_ONE = COL_BITS'(1);
  localparam logic [ROW_BITS-1:0] Y_ONE = ROW_BITS'(1);
  localparam logic [COL_BITS-1:0] X_MAX = '1;
  localparam logic [ROW_BITS-1:0] Y_MAX = '1;

  state_t            state;
  logic [AW-1:0]     cnt;
  logic [COL_BITS-1:0] x;
  logic [ROW_BITS-1:0] y;
  logic              busy_q, done_q, rom_rd_q, ram_valid_q;
  logic [DATA_W-1:0] mem [N];
  logic [AW-1:0]     a0, a1, a2, a3;
  logic [DATA_W-1:0] p0, p1, p2, p3;
  logic [DATA_W-1:0] max_v, min_v, avg_v;
  logic              cmd_go;

  assign a0 = {y - Y_ONE, x - X_ONE};
  assign a1 = {y - Y_ONE, x};
  assign a2 = {y, x - X_ONE};
  assign a3 = {y, x};
  assign p0 = mem[a0];
  assign p1 = mem[a1];
  assign p2 = mem[a2];
  assign p3 = mem[a3];
  assign cmd_go = (state == ST_CMD) && bus.cmd_valid;

  lcd_win_alu #(.DATA_W(DATA_W), .AVG_ROUND(AVG_ROUND)) u_alu (
    .p0(p0), .p1(p1), .p2(p2), .p3(p3),
    .max_v(max_v), .min_v(min_v), .avg_v(avg_v)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      x           <= X_MID;
      y           <= Y_MID;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
      rom_rd_q    <= 1'b0;
      ram_valid_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          state    <= ST_READ;
          cnt      <= '0;
          rom_rd_q <= 1'b1;
        end
        ST_READ: begin
          cnt <= cnt + AW'(1);
          if (cnt == '1) begin
            state    <= ST_CMD;
            rom_rd_q <= 1'b0;
            busy_q   <= 1'b0;
          end
        end
        ST_CMD: begin
          if (bus.cmd_valid) begin
            case (bus.cmd)
              CMD_WRITE: begin
                state       <= ST_WRITE;
                cnt         <= '0;
                ram_valid_q <= 1'b1;
                busy_q      <= 1'b1;
              end
              CMD_UP:     if (y > Y_ONE) y <= y - Y_ONE;
              CMD_DOWN:   if (y < Y_MAX) y <= y + Y_ONE;
              CMD_LEFT:   if (x > X_ONE) x <= x - X_ONE;
              CMD_RIGHT:  if (x < X_MAX) x <= x + X_ONE;
              CMD_CENTER: begin
                x <= X_MID;
                y <= Y_MID;
              end
              CMD_RELOAD: begin
                x      <= X_MID;
                y      <= Y_MID;
                state  <= ST_IDLE;
                busy_q <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        ST_WRITE: begin
          cnt <= cnt + AW'(1);
          if (cnt == '1) begin
            state       <= ST_DONE;
            ram_valid_q <= 1'b0;
            done_q      <= 1'b1;
          end
        end
        ST_DONE: begin
          state  <= ST_CMD;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
        default: begin
          state       <= ST_IDLE;
          busy_q      <= 1'b1;
          done_q      <= 1'b0;
          rom_rd_q    <= 1'b0;
          ram_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // window updates read pre-edge pixels, so rotations need no temporaries
  always_ff @(posedge clk) begin
    if (state == ST_READ) begin
      mem[cnt] <= bus.IROM_Q;
    end else if (cmd_go) begin
      case (bus.cmd)
        CMD_MAX:  begin mem[a0] <= max_v; mem[a1] <= max_v; mem[a2] <= max_v; mem[a3] <= max_v; end
        CMD_MIN:  begin mem[a0] <= min_v; mem[a1] <= min_v; mem[a2] <= min_v; mem[a3] <= min_v; end
        CMD_AVG:  begin mem[a0] <= avg_v; mem[a1] <= avg_v; mem[a2] <= avg_v; mem[a3] <= avg_v; end
        CMD_CCW:  begin mem[a0] <= p1; mem[a1] <= p3; mem[a3] <= p2; mem[a2] <= p0; end
        CMD_CW:   begin mem[a0] <= p2; mem[a1] <= p0; mem[a3] <= p1; mem[a2] <= p3; end
        CMD_MIRX: begin mem[a0] <= p2; mem[a2] <= p0; mem[a1] <= p3; mem[a3] <= p1; end
        CMD_MIRY: begin mem[a0] <= p1; mem[a1] <= p0; mem[a2] <= p3; mem[a3] <= p2; end
        default: ;
      endcase
    end
  end

  assign bus.IROM_rd    = rom_rd_q;
  assign bus.IROM_A     = rom_rd_q ? cnt : '0;
  assign bus.IRAM_valid = ram_valid_q;
  assign bus.IRAM_A     = ram_valid_q ? cnt : '0;
  assign bus.IRAM_D     = mem[cnt];
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
endmodule

// File: tb/tb_lcd_ctrl_param.sv
// Bench for lcd_ctrl_param: 8x8 truncating, 8x8 rounding and 4x4 instances with ROM[a]=a.
module tb_lcd_ctrl_param;
  import lcd_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lcd_ctrl_param_if #(.DATA_W(8), .AW(6)) ifc0 ();
  lcd_ctrl_param_if #(.DATA_W(8), .AW(6)) ifc1 ();
  lcd_ctrl_param_if #(.DATA_W(8), .AW(4)) ifc2 ();

  lcd_ctrl_param #(.DATA_W(8), .COL_BITS(3), .ROW_BITS(3), .AVG_ROUND(0)) dut0 (
    .clk(clk), .reset(reset), .bus(ifc0.slave));
  lcd_ctrl_param #(.DATA_W(8), .COL_BITS(3), .ROW_BITS(3), .AVG_ROUND(1)) dut1 (
    .clk(clk), .reset(reset), .bus(ifc1.slave));
  lcd_ctrl_param #(.DATA_W(8), .COL_BITS(2), .ROW_BITS(2), .AVG_ROUND(0)) dut2 (
    .clk(clk), .reset(reset), .bus(ifc2.slave));

  assign ifc0.IROM_Q = 8'(ifc0.IROM_A);
  assign ifc1.IROM_Q = 8'(ifc1.IROM_A);
  assign ifc2.IROM_Q = 8'(ifc2.IROM_A);

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [5:0] a;
    logic [7:0] d;
  } exp_t;
  exp_t sb_q[$];
  logic [7:0] img [64];
  bit mon_en = 1'b1;
  logic [7:0] cap1 [64];
  logic [7:0] cap2 [16];

  // scoreboard for the default instance: every IRAM write pops one expected entry
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && ifc0.IRAM_valid) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got addr=%0d data=%0d required no write", ifc0.IRAM_A, ifc0.IRAM_D);
      end else begin
        e = sb_q.pop_front();
        if (ifc0.IRAM_A !== e.a || ifc0.IRAM_D !== e.d) begin
          errors++;
          $display("FAIL sb_write got addr=%0d data=%0d required addr=%0d data=%0d",
                   ifc0.IRAM_A, ifc0.IRAM_D, e.a, e.d);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (ifc1.IRAM_valid) cap1[ifc1.IRAM_A] = ifc1.IRAM_D;
    if (ifc2.IRAM_valid) cap2[ifc2.IRAM_A] = ifc2.IRAM_D;
  end

  function automatic logic busy_of(input int w);
    return (w == 0) ? ifc0.busy : (w == 1) ? ifc1.busy : ifc2.busy;
  endfunction
  function automatic logic valid_of(input int w);
    return (w == 0) ? ifc0.IRAM_valid : (w == 1) ? ifc1.IRAM_valid : ifc2.IRAM_valid;
  endfunction
  function automatic logic done_of(input int w);
    return (w == 0) ? ifc0.done : (w == 1) ? ifc1.done : ifc2.done;
  endfunction

  task automatic drive(input int w, input logic [3:0] c, input logic v);
    case (w)
      0: begin ifc0.cmd = c; ifc0.cmd_valid = v; end
      1: begin ifc1.cmd = c; ifc1.cmd_valid = v; end
      default: begin ifc2.cmd = c; ifc2.cmd_valid = v; end
    endcase
  endtask

  task automatic set_identity();
    for (int i = 0; i < 64; i++) img[i] = 8'(i);
  endtask

  task automatic push_image();
    exp_t e;
    for (int i = 0; i < 64; i++) begin
      e.a = 6'(i);
      e.d = img[i];
      sb_q.push_back(e);
    end
  endtask

  task automatic send_cmd(input int w, input logic [3:0] c);
    int n;
    n = 0;
    @(negedge clk);
    while (busy_of(w) !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      checks++;
      errors++;
      $display("FAIL send_cmd_timeout dut=%0d busy=%b required 0", w, busy_of(w));
    end
    drive(w, c, 1'b1);
    @(posedge clk);
    #1 drive(w, c, 1'b0);
  endtask

  task automatic run_write(input int w, output int vcnt, output int dcnt, output int lastv,
                           output int dpos, output logic busy_after, output bit to);
    vcnt = 0; dcnt = 0; lastv = -1; dpos = -1; busy_after = 1'b1; to = 1'b1;
    send_cmd(w, CMD_WRITE);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (dcnt > 0 && i == dpos + 1) begin
        busy_after = busy_of(w);
        to = 1'b0;
        break;
      end
      if (valid_of(w)) begin vcnt++; lastv = i; end
      if (done_of(w)) begin dcnt++; dpos = i; end
    end
  endtask

  task automatic test_reset();
    int rd2;
    reset = 1'b0;
    drive(0, 4'd0, 1'b0); drive(1, 4'd0, 1'b0); drive(2, 4'd0, 1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if (ifc0.busy !== 1'b1 || ifc0.done !== 1'b0 || ifc0.IROM_rd !== 1'b0 ||
        ifc0.IRAM_valid !== 1'b0 || ifc0.IROM_A !== 6'd0 || ifc0.IRAM_A !== 6'd0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b done=%b rd=%b valid=%b roma=%0d rama=%0d required 1 0 0 0 0 0",
               ifc0.busy, ifc0.done, ifc0.IROM_rd, ifc0.IRAM_valid, ifc0.IROM_A, ifc0.IRAM_A);
    end
    reset = 1'b1;
    rd2 = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      rd2 += int'(ifc2.IROM_rd);
      checks++;
      if (ifc0.busy !== 1'b1 || ifc0.IROM_rd !== 1'b1 || ifc0.IROM_A !== 6'(i)) begin
        errors++;
        $display("FAIL read_sweep cycle %0d got busy=%b rd=%b addr=%0d required 1 1 %0d",
                 i, ifc0.busy, ifc0.IROM_rd, ifc0.IROM_A, i);
      end
    end
    @(negedge clk);
    checks++;
    if (ifc0.busy !== 1'b0 || ifc0.IROM_rd !== 1'b0) begin
      errors++;
      $display("FAIL read_end got busy=%b rd=%b required 0 0", ifc0.busy, ifc0.IROM_rd);
    end
    checks++;
    if (rd2 != 16) begin
      errors++;
      $display("FAIL small_read_len got %0d required 16", rd2);
    end
  endtask

  task automatic test_write_out();
    int vcnt, dcnt, lastv, dpos;
    logic busy_after;
    bit to;
    for (int k = 0; k < 2; k++) begin
      set_identity();
      push_image();
      run_write(0, vcnt, dcnt, lastv, dpos, busy_after, to);
      checks++;
      if (to || vcnt != 64 || dcnt != 1 || dpos != lastv + 1 || busy_after !== 1'b0) begin
        errors++;
        $display("FAIL write_out pass %0d got to=%0d valid=%0d done=%0d donepos=%0d lastvalid=%0d busy=%b required 0 64 1 lastvalid+1 0",
                 k, to, vcnt, dcnt, dpos, lastv, busy_after);
      end
      checks++;
      if (sb_q.size() != 0) begin
        errors++;
        $display("FAIL write_out_left pass %0d got %0d pending required 0", k, sb_q.size());
      end
    end
  endtask

  task automatic test_arith();
    logic [3:0] ops [3];
    int res [3];
    int vcnt, dcnt, lastv, dpos;
    logic busy_after;
    bit to;
    ops = '{CMD_MAX, CMD_MIN, CMD_AVG};
    res = '{36, 27, 31};
    for (int k = 0; k < 3; k++) begin
      send_cmd(0, CMD_RELOAD);
      send_cmd(0, ops[k]);
      set_identity();
      img[27] = 8'(res[k]); img[28] = 8'(res[k]); img[35] = 8'(res[k]); img[36] = 8'(res[k]);
      push_image();
      run_write(0, vcnt, dcnt, lastv, dpos, busy_after, to);
      checks++;
      if (to || vcnt != 64 || sb_q.size() != 0) begin
        errors++;
        $display("FAIL arith op %0d got to=%0d valid=%0d pending=%0d required 0 64 0",
                 ops[k], to, vcnt, sb_q.size());
      end
    end
  endtask

  task automatic test_rotation();
    int vcnt, dcnt, lastv, dpos;
    logic busy_after;
    bit to;
    logic [3:0] seq [4];
    int ex [4][4];
    seq = '{CMD_CW, CMD_CCW, CMD_MIRX, CMD_MIRY};
    ex = '{'{35, 27, 36, 28}, '{27, 28, 35, 36}, '{35, 36, 27, 28}, '{28, 27, 36, 35}};
    send_cmd(0, CMD_RELOAD);
    for (int k = 0; k < 4; k++) begin
      if (k == 2 || k == 3) send_cmd(0, CMD_RELOAD);
      send_cmd(0, seq[k]);
      set_identity();
      img[27] = 8'(ex[k][0]); img[28] = 8'(ex[k][1]); img[35] = 8'(ex[k][2]); img[36] = 8'(ex[k][3]);
      push_image();
      run_write(0, vcnt, dcnt, lastv, dpos, busy_after, to);
      checks++;
      if (to || vcnt != 64 || sb_q.size() != 0) begin
        errors++;
        $display("FAIL rotation op %0d got to=%0d valid=%0d pending=%0d required 0 64 0",
                 seq[k], to, vcnt, sb_q.size());
      end
    end
  endtask

  task automatic shift_and_check(input logic [3:0] op, input logic [3:0] mv1, input logic [3:0] mv2,
                                 input int a0, input int v, input logic reload);
    int vcnt, dcnt, lastv, dpos;
    logic busy_after;
    bit to;
    if (reload) begin
      send_cmd(0, CMD_RELOAD);
      set_identity();
    end
    for (int i = 0; i < 5; i++) begin
      send_cmd(0, mv1);
      send_cmd(0, mv2);
    end
    push_image();
    run_write(0, vcnt, dcnt, lastv, dpos, busy_after, to);
    send_cmd(0, op);
    img[a0] = 8'(v); img[a0+1] = 8'(v); img[a0+8] = 8'(v); img[a0+9] = 8'(v);
    push_image();
    run_write(0, vcnt, dcnt, lastv, dpos, busy_after, to);
  endtask

  task automatic test_saturation();
    shift_and_check(CMD_MAX, CMD_UP, 4'd14, 3, 12, 1'b1);
    checks++;
    if (sb_q.size() != 0 || img[11] !== 8'd12) begin
      errors++;
      $display("FAIL sat_up got pending=%0d required 0", sb_q.size());
    end
    shift_and_check(CMD_MIN, CMD_RIGHT, 4'd15, 30, 30, 1'b1);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sat_right got pending=%0d required 0", sb_q.size());
    end
    send_cmd(0, CMD_CENTER);
    shift_and_check(CMD_MAX, 4'd14, 4'd15, 27, 36, 1'b0);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL recenter got pending=%0d required 0", sb_q.size());
    end
    shift_and_check(CMD_MAX, CMD_DOWN, CMD_LEFT, 48, 57, 1'b1);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sat_down_left got pending=%0d required 0", sb_q.size());
    end
  endtask

  task automatic test_avg_round();
    int vcnt, dcnt, lastv, dpos;
    logic busy_after;
    bit to;
    for (int i = 0; i < 64; i++) cap1[i] = 8'hEE;
    send_cmd(1, CMD_AVG);
    run_write(1, vcnt, dcnt, lastv, dpos, busy_after, to);
    checks++;
    if (to || cap1[27] !== 8'd32 || cap1[28] !== 8'd32 || cap1[35] !== 8'd32 ||
        cap1[36] !== 8'd32 || cap1[26] !== 8'd26 || cap1[37] !== 8'd37) begin
      errors++;
      $display("FAIL avg_round got %0d %0d %0d %0d edges %0d %0d required 32 32 32 32 edges 26 37",
               cap1[27], cap1[28], cap1[35], cap1[36], cap1[26], cap1[37]);
    end
  endtask

  task automatic test_small();
    int vcnt, dcnt, lastv, dpos;
    logic busy_after;
    bit to;
    for (int i = 0; i < 16; i++) cap2[i] = 8'hEE;
    send_cmd(2, CMD_MAX);
    run_write(2, vcnt, dcnt, lastv, dpos, busy_after, to);
    checks++;
    if (to || vcnt != 16 || cap2[5] !== 8'd10 || cap2[6] !== 8'd10 || cap2[9] !== 8'd10 ||
        cap2[10] !== 8'd10 || cap2[4] !== 8'd4) begin
      errors++;
      $display("FAIL small_center got valid=%0d %0d %0d %0d %0d edge %0d required 16 10 10 10 10 edge 4",
               vcnt, cap2[5], cap2[6], cap2[9], cap2[10], cap2[4]);
    end
    send_cmd(2, CMD_RELOAD);
    for (int i = 0; i < 6; i++) send_cmd(2, CMD_RIGHT);
    send_cmd(2, CMD_MAX);
    run_write(2, vcnt, dcnt, lastv, dpos, busy_after, to);
    checks++;
    if (to || cap2[6] !== 8'd11 || cap2[7] !== 8'd11 || cap2[10] !== 8'd11 ||
        cap2[11] !== 8'd11 || cap2[5] !== 8'd5 || cap2[9] !== 8'd9) begin
      errors++;
      $display("FAIL small_right_sat got %0d %0d %0d %0d edges %0d %0d required 11 11 11 11 edges 5 9",
               cap2[6], cap2[7], cap2[10], cap2[11], cap2[5], cap2[9]);
    end
  endtask

  task automatic test_reset_mid_write();
    int n, rdc, vcnt, dcnt, lastv, dpos;
    logic busy_after;
    bit to;
    mon_en = 1'b0;
    send_cmd(0, CMD_WRITE);
    n = 0;
    @(negedge clk);
    while (!(ifc0.IRAM_valid === 1'b1 && ifc0.IRAM_A === 6'd20) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL midwrite_reach got addr=%0d required 20", ifc0.IRAM_A);
    end
    drive(0, CMD_RIGHT, 1'b1);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (ifc0.IRAM_valid !== 1'b0 || ifc0.IRAM_A !== 6'd0 || ifc0.busy !== 1'b1 ||
        ifc0.done !== 1'b0 || ifc0.IROM_rd !== 1'b0) begin
      errors++;
      $display("FAIL midwrite_reset got valid=%b addr=%0d busy=%b done=%b rd=%b required 0 0 1 0 0",
               ifc0.IRAM_valid, ifc0.IRAM_A, ifc0.busy, ifc0.done, ifc0.IROM_rd);
    end
    @(negedge clk);
    reset = 1'b1;
    mon_en = 1'b1;
    rdc = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      rdc += int'(ifc0.IROM_rd);
      if (i == 60) drive(0, CMD_RIGHT, 1'b0);
    end
    checks++;
    if (rdc != 64) begin
      errors++;
      $display("FAIL reread_len got %0d required 64", rdc);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (ifc0.busy !== 1'b0 || ifc0.IRAM_valid !== 1'b0) begin
        errors++;
        $display("FAIL after_reload cycle %0d got busy=%b valid=%b required 0 0", i, ifc0.busy, ifc0.IRAM_valid);
      end
    end
    send_cmd(0, CMD_MAX);
    set_identity();
    img[27] = 8'd36; img[28] = 8'd36; img[35] = 8'd36; img[36] = 8'd36;
    push_image();
    run_write(0, vcnt, dcnt, lastv, dpos, busy_after, to);
    checks++;
    if (to || vcnt != 64 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL busy_cmd_ignored got to=%0d valid=%0d pending=%0d required 0 64 0", to, vcnt, sb_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_write_out();
    test_arith();
    test_rotation();
    test_saturation();
    test_avg_round();
    test_small();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lcd_ctrl_param.md
Name: lcd_ctrl_param

Overview:
- Parametrised successor of the 8x8 LCD image controller.
- Loads a W x H greyscale image from IROM into an internal buffer.
- Applies host commands to a 2x2 window at a movable cursor, then streams the image to IRAM.
- Generalised in pixel width, image dimensions and averaging rounding. New over the previous generation: mirror-Y, recenter and reload commands, plus return-to-command after write-out so one image can be written repeatedly.

Parameters:
- DATA_W, 8, pixel width in bits.
- COL_BITS, 3, log2 image width (W = 2**COL_BITS, minimum 1).
- ROW_BITS, 3, log2 image height (H = 2**ROW_BITS, minimum 1).
- AVG_ROUND, 0, averaging mode: 0 = truncate sum/4, 1 = round half up, i.e. (sum+2)/4.
- AW (local), COL_BITS+ROW_BITS, address width; N = 2**AW pixels.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- cmd  in  4  command opcode
- cmd_valid  in  1  command strobe; sampled only while busy=0
- IROM_Q  in  DATA_W  ROM data; combinationally valid for the IROM_A of the same cycle
- IROM_rd  out  1  ROM read enable
- IROM_A  out  AW  ROM address
- IRAM_valid  out  1  RAM write strobe
- IRAM_D  out  DATA_W  RAM write data
- IRAM_A  out  AW  RAM address
- busy  out  1  high when a command cannot be accepted
- done  out  1  one-cycle pulse at end of write-out

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, cnt=0, cursor x=W/2, y=H/2.
  - Outputs during reset: busy=1, done=0, IROM_rd=0, IRAM_valid=0, IROM_A=IRAM_A=0.
  - Buffer contents are not reset.
  - Reset asserted mid-READ or mid-WRITE aborts immediately; after release the block restarts from IDLE.
- Address mapping: pixel (row r, col c) sits at address {r,c}, row-major.
- Cursor range: x in [1,W-1], y in [1,H-1].
- Window pixels: P0=(y-1,x-1), P1=(y-1,x), P2=(y,x-1), P3=(y,x).
- FSM states: IDLE, READ, CMD, WRITE, DONE.
  - IDLE: one cycle, busy=1, then READ.
  - READ: N cycles. IROM_rd=1, IROM_A=cnt, buffer[cnt]<=IROM_Q, cnt++. Goes to CMD when cnt==N-1 (cnt wraps to 0).
  - CMD: busy=0. A command is accepted on a cycle with cmd_valid=1 and takes effect at that clock edge. No cmd_valid means the block holds.
  - WRITE: N cycles. IRAM_valid=1, IRAM_A=cnt, IRAM_D=buffer[cnt] (current cycle, combinational read). Goes to DONE at cnt==N-1.
  - DONE: one cycle, done=1, busy=1, then CMD. Cursor and buffer are retained.
- busy is 1 in every state except CMD.
- cnt is forced to 0 on entry to READ and to WRITE.
- Command set (all single-cycle):
  - 0 write: go to WRITE.
  - 1 up: y-- if y>1.
  - 2 down: y++ if y<H-1.
  - 3 left: x-- if x>1.
  - 4 right: x++ if x<W-1.
  - Shifts at a boundary are no-ops; the cursor saturates and never wraps.
  - 5 max: all four window pixels <= max(P0..P3).
  - 6 min: all four window pixels <= min(P0..P3).
  - 7 avg: all four window pixels <= average. The sum is computed at DATA_W+2 bits so it never overflows. Truncate or round per AVG_ROUND. Round mode cannot exceed 2**DATA_W-1 because sum+2 ≤ 4*(2**DATA_W-1)+2 still yields ≤ 2**DATA_W-1 after >>2.
  - 8 CCW: P0<-P1, P1<-P3, P3<-P2, P2<-P0.
  - 9 CW: P0<-P2, P1<-P0, P3<-P1, P2<-P3.
  - 10 mirror X: swap P0<->P2 and P1<->P3.
  - 11 mirror Y: swap P0<->P1 and P2<->P3.
  - 12 recenter: x=W/2, y=H/2.
  - 13 reload: cursor recentered, go to IDLE (the ROM is read again).
  - 14, 15: no-op, stay in CMD.
- All four window writes use pre-edge values (no read-after-write ordering).
- cmd_valid while busy=1 is ignored and never queued.

Decomposition:
- Package lcd_ctrl_pkg holds:
  - the state encoding;
  - command opcode constants: CMD_WRITE=0, CMD_UP=1, CMD_DOWN=2, CMD_LEFT=3, CMD_RIGHT=4, CMD_MAX=5, CMD_MIN=6, CMD_AVG=7, CMD_CCW=8, CMD_CW=9, CMD_MIRX=10, CMD_MIRY=11, CMD_CENTER=12, CMD_RELOAD=13.
- One sub-module, lcd_win_alu: purely combinational. Takes P0..P3 and produces max, min and avg; parameters DATA_W and AVG_ROUND.

Test Plan:
- Default params, ROM[a]=a. Release reset. Required: busy=1 for 1+64 cycles; IROM_A sweeps 0..63 with IROM_rd=1; then busy=0. Cursor (4,4) window reads P0=27, P1=28, P2=35, P3=36.
- Arithmetic on that image, reloading (cmd 13) before each:
  - cmd 5: addresses 27, 28, 35, 36 all become 36.
  - cmd 6: all become 27.
  - cmd 7 with AVG_ROUND=0: all become 31.
  - cmd 7 with AVG_ROUND=1: all become 32.
- Rotation: cmd 9 gives addr27=35, addr28=27, addr35=36, addr36=28. Following it with cmd 8 restores 27, 28, 35, 36.
- Cursor saturation: issue cmd 1 five times then cmd 0. Required: y=1, IRAM writes 0..63 unchanged. Repeat with cmd 4 five times: x=7.
- Write-out: cmd 0. Required: IRAM_valid=1 for exactly 64 cycles with IRAM_A=0..63; done=1 for exactly the next cycle; busy=0 the cycle after. cmd 0 again produces an identical stream.
- Reset mid-WRITE at cnt=20 with cmd_valid=1 during busy. Required: outputs clear immediately; the busy-time command is ignored; a fresh 64-cycle READ follows. Also run with COL_BITS=2, ROW_BITS=2: 16-cycle READ, cursor (2,2), a sixth shift-right leaves x=3.
